// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 asynchronous serial receiver, LSB first.
// The UART_RX pin passes through a two-flop synchronizer. All frame timing is
// counted from the first cycle the synchronized line (rx_s) reads 0.
// Start, data and stop bits are sampled at their bit centres.
// A good frame updates RX_DATA and pulses RX_STATUS for one cycle.
// A stop bit sampled low pulses RX_ERR for one cycle. The receiver then parks
// in BREAK until the line goes high again.
//
// Handshake: there is no back-pressure. RX_STATUS is a one-cycle "valid" pulse
// that qualifies RX_DATA. RX_DATA keeps its value until the next good frame,
// so a consumer that misses the pulse can still read the byte.
//
// BIT_CYCLES must be even and at least 4 so that HALF lands on a whole cycle
// strictly inside the start bit.
module uart_receiver #(
    parameter int  BIT_CYCLES = 16,
    localparam int HALF       = BIT_CYCLES / 2
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       UART_RX,
    output logic [7:0] RX_DATA,
    output logic       RX_STATUS,
    output logic       RX_ERR,
    output logic       RX_BUSY,
    output logic [2:0] dbg_state_o
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic            rx_s;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            status_q, status_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            half_pt;
    logic            bit_pt;

    assign rx_s = sync2_q;

    // Sample points. The counter restarts at 0 on the cycle after each sample,
    // so the first START cycle (t0+1) holds count 0.
    // half_pt: count HALF-1, i.e. cycle t0+HALF.
    // bit_pt: count BIT_CYCLES-1, i.e. the centre of each later bit.
    assign half_pt = (cnt_q == CW'(HALF - 1));
    assign bit_pt  = (cnt_q == CW'(BIT_CYCLES - 1));

    // Two-flop synchronizer. Both flops reset to idle-high so that leaving
    // reset never looks like a start edge.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= UART_RX;
            sync2_q <= sync1_q;
        end
    end

    // State register and datapath registers.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            status_q  <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            status_q  <= status_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                // A line that is back high at mid-start was a glitch.
                if (half_pt) state_d = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (bit_pt && (bit_idx_q == 3'd7)) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_pt) state_d = rx_s ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                // Hold here while the line stays low. A long break then
                // produces one error, not a stream of 0x00 frames.
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bit-timing counter, bit index and shift register.
    always_comb begin
        cnt_d     = '0;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
            end
            S_START: begin
                if (half_pt) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_pt) begin
                    cnt_d     = '0;
                    // The LSB arrives first and ends up in bit 0 after 8 shifts.
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                cnt_d = bit_pt ? '0 : cnt_q + CW'(1);
            end
            S_BREAK: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Next values of the registered outputs.
    // The strobes are decoded from the stop-bit sample and appear one cycle later.
    always_comb begin
        status_d = (state_q == S_STOP) && bit_pt && rx_s;
        err_d    = (state_q == S_STOP) && bit_pt && !rx_s;
        data_d   = status_d ? shift_q : data_q;
        busy_d   = (state_d != S_IDLE);
    end

    assign RX_DATA     = data_q;
    assign RX_STATUS   = status_q;
    assign RX_ERR      = err_q;
    assign RX_BUSY     = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver at 16 cycles per bit.
// A table of frames covers the single good frame, the framing error with a
// held break, and back-to-back frames. Hand-written sequences cover:
// - the start-bit glitch,
// - exact strobe latency,
// - reset in the middle of a frame,
// - a full 0x00..0xFF transmitter loopback.
module tb_uart_receiver;

    localparam int BC = 16;

    logic       sysclk  = 1'b0;
    logic       reset   = 1'b0;
    logic       UART_RX = 1'b1;
    logic [7:0] RX_DATA;
    logic       RX_STATUS;
    logic       RX_ERR;
    logic       RX_BUSY;
    logic [2:0] dbg_state;

    int n_vec      = 0;
    int n_bad      = 0;
    int status_cnt = 0;
    int err_cnt    = 0;
    int both_cnt   = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        int         stop_low;
        int         idle_bits;
        int         exp_status;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    uart_receiver #(.BIT_CYCLES(BC)) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .UART_RX    (UART_RX),
        .RX_DATA    (RX_DATA),
        .RX_STATUS  (RX_STATUS),
        .RX_ERR     (RX_ERR),
        .RX_BUSY    (RX_BUSY),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 sysclk = ~sysclk;

    // ---------------- scoreboard / monitor ----------------
    always @(negedge sysclk) begin
        if (reset) begin
            if (RX_STATUS && RX_ERR) begin
                both_cnt++;
            end
            if (RX_ERR) begin
                err_cnt++;
            end
            if (RX_STATUS) begin
                status_cnt++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_strobe: got RX_DATA=%02h, expected no strobe", RX_DATA);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (RX_DATA !== e) begin
                        n_bad++;
                        $display("FAIL strobe_data: got %02h expected %02h", RX_DATA, e);
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        UART_RX = b;
        repeat (BC) @(negedge sysclk);
    endtask

    // Start bit, 8 data bits LSB first, then either one high stop bit or
    // stop_low bit-times of low line (a framing error that runs into a break).
    task automatic send_frame(input logic [7:0] d, input int stop_low);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (stop_low == 0) begin
            send_bit(1'b1);
        end else begin
            repeat (stop_low) send_bit(1'b0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s0;
        int e0;
        logic [9:0] fb;

        vecs[0] = '{8'hA5, 0, 2, 1, 0, 8'hA5};
        vecs[1] = '{8'h3C, 3, 2, 0, 1, 8'hA5};
        vecs[2] = '{8'h00, 0, 0, 1, 0, 8'h00};
        vecs[3] = '{8'hFF, 0, 0, 1, 0, 8'hFF};
        vecs[4] = '{8'h81, 0, 2, 1, 0, 8'h81};
        vecs[5] = '{8'h5A, 0, 2, 1, 0, 8'h5A};

        // Reset values.
        reset   = 1'b0;
        UART_RX = 1'b1;
        repeat (3) @(negedge sysclk);
        check("reset_rx_data", RX_DATA, 8'h00);
        check("reset_status", RX_STATUS, 1'b0);
        check("reset_err", RX_ERR, 1'b0);
        check("reset_busy", RX_BUSY, 1'b0);
        reset = 1'b1;
        repeat (4) @(negedge sysclk);

        // Table-driven frames.
        for (int v = 0; v < 6; v++) begin
            s0 = status_cnt;
            e0 = err_cnt;
            if (vecs[v].exp_status != 0) exp_q.push_back(vecs[v].data);
            send_frame(vecs[v].data, vecs[v].stop_low);
            if (vecs[v].stop_low != 0) check($sformatf("v%0d_break_busy", v), RX_BUSY, 1'b1);
            check($sformatf("v%0d_status_count", v), status_cnt - s0, vecs[v].exp_status);
            check($sformatf("v%0d_err_count", v), err_cnt - e0, vecs[v].exp_err);
            check($sformatf("v%0d_rx_data", v), RX_DATA, vecs[v].exp_data);
            repeat (vecs[v].idle_bits) send_bit(1'b1);
            if (vecs[v].idle_bits != 0) check($sformatf("v%0d_idle_busy", v), RX_BUSY, 1'b0);
        end

        // Glitch of 4 cycles on an idle line.
        s0 = status_cnt;
        e0 = err_cnt;
        UART_RX = 1'b0;
        repeat (4) @(negedge sysclk);
        UART_RX = 1'b1;
        check("glitch_busy_high", RX_BUSY, 1'b1);
        repeat (12) @(negedge sysclk);
        check("glitch_busy_low", RX_BUSY, 1'b0);
        repeat (2 * BC) @(negedge sysclk);
        check("glitch_no_status", status_cnt - s0, 0);
        check("glitch_no_err", err_cnt - e0, 0);
        check("glitch_rx_data", RX_DATA, 8'h5A);

        // Exact latency: the strobe is first seen on the 155th rising edge
        // after the pin falls.
        // Derivation: 2 edges of synchronizer, HALF + 9*BC = 152 cycles to
        // the stop-bit sample, and 1 edge for the registered strobe.
        fb = {1'b1, 8'h96, 1'b0};
        exp_q.push_back(8'h96);
        for (int c = 0; c < 10 * BC; c++) begin
            UART_RX = fb[c / BC];
            @(negedge sysclk);
            if (c + 1 == 154) check("latency_not_early", RX_STATUS, 1'b0);
            if (c + 1 == 155) check("latency_on_time", RX_STATUS, 1'b1);
        end
        UART_RX = 1'b1;
        repeat (2 * BC) @(negedge sysclk);
        check("latency_rx_data", RX_DATA, 8'h96);

        // Reset asserted during data bit 4 of 0xC3.
        s0 = status_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(fb[0] | 1'b1 ? ((8'hC3 >> i) & 8'h01) != 0 : 1'b0);
        UART_RX = 1'b0;
        repeat (8) @(negedge sysclk);
        check("pre_reset_busy", RX_BUSY, 1'b1);
        reset   = 1'b0;
        UART_RX = 1'b1;
        #1;
        check("midreset_rx_data", RX_DATA, 8'h00);
        check("midreset_status", RX_STATUS, 1'b0);
        check("midreset_err", RX_ERR, 1'b0);
        check("midreset_busy", RX_BUSY, 1'b0);
        repeat (3) @(negedge sysclk);
        reset = 1'b1;
        repeat (2 * BC) @(negedge sysclk);
        check("after_reset_no_strobe", status_cnt - s0, 0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 0);
        send_bit(1'b1);
        check("after_reset_status", status_cnt - s0, 1);
        check("after_reset_rx_data", RX_DATA, 8'h5A);

        // Transmitter loopback: every byte in order, back to back.
        s0 = status_cnt;
        e0 = err_cnt;
        for (int b = 0; b < 256; b++) begin
            exp_q.push_back(8'(b));
            send_frame(8'(b), 0);
        end
        repeat (2) send_bit(1'b1);
        check("loopback_status", status_cnt - s0, 256);
        check("loopback_err", err_cnt - e0, 0);
        check("loopback_rx_data", RX_DATA, 8'hFF);
        check("loopback_busy", RX_BUSY, 1'b0);

        // Final report.
        check("exp_q_drained", exp_q.size(), 0);
        check("status_err_overlap", both_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
